// File: rtl/async_pkg.sv
// ============================================================================
// Module : async_pkg
// Brief  : Shared constants and helpers for the two-phase channel blocks.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package async_pkg;

  localparam int MIN_SYNC_STAGES = 2;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit sync_ok(input int stages);
    return stages >= MIN_SYNC_STAGES;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_bit.sv
// ============================================================================
// Module : sync_bit
// Brief  : Multi-flop single-bit synchronizer with synchronous clear.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_bit
  import async_pkg::*;
#(
  parameter int STAGES = MIN_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/twophase_sync_rx.sv
// ============================================================================
// Module : twophase_sync_rx
// Brief  : Two-phase bundled-data receiver: synchronize req, buffer data in a
//          small FIFO, answer with a transition on ack, steer dot/blank events.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module twophase_sync_rx
  import async_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_in,
  input  logic [WIDTH-1:0]            data_in,
  output logic                        ack_out,
  output logic                        dout_valid,
  output logic [WIDTH-1:0]            dout_data,
  input  logic                        dout_ready,
  output logic                        evt_dot,
  output logic                        evt_blank,
  output logic [ptr_width(DEPTH)-1:0] level
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int AW    = PTR_W - 1;

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("twophase_sync_rx: DEPTH must be a power of two and >= 2");
  end
  if (!sync_ok(SYNC_STAGES)) begin : g_bad_sync
    $error("twophase_sync_rx: SYNC_STAGES below minimum");
  end

  logic             w_req_sync;
  logic             r_req_seen;
  logic             r_ack;
  logic             r_evt_dot;
  logic             r_evt_blank;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_pending;
  logic             w_accept;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (req_in),
    .q   (w_req_sync)
  );

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop     = !w_empty && dout_ready;
  assign w_pending = (w_req_sync != r_req_seen);
  // A pop frees a slot this same edge, so a full FIFO may still accept.
  assign w_accept  = w_pending && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_req_seen  <= 1'b0;
      r_ack       <= 1'b0;
      r_evt_dot   <= 1'b0;
      r_evt_blank <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
        r_req_seen <= w_req_sync;
        r_ack      <= w_req_sync;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_evt_dot   <= w_accept && w_req_sync;
      r_evt_blank <= w_accept && !w_req_sync;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_mem[r_wr_ptr[AW-1:0]] <= data_in;
    end
  end

  assign ack_out    = r_ack;
  assign evt_dot    = r_evt_dot;
  assign evt_blank  = r_evt_blank;
  assign dout_valid = !w_empty;
  assign dout_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign level      = r_wr_ptr - r_rd_ptr;

endmodule

`default_nettype wire

// File: tb/tb_twophase_sync_rx.sv
// ============================================================================
// Module : tb_twophase_sync_rx
// Brief  : Directed self-checking bench for the two-phase receiver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_twophase_sync_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_in;
  logic [7:0] data_in;
  logic       ack_out;
  logic       dout_valid;
  logic [7:0] dout_data;
  logic       dout_ready;
  logic       evt_dot;
  logic       evt_blank;
  logic [2:0] level;

  logic       req3;
  logic [7:0] data3;
  logic       ack3;
  logic       valid3;
  logic [7:0] dout3;
  logic       ready3;
  logic       dot3;
  logic       blank3;
  logic [2:0] level3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  twophase_sync_rx #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req_in),
    .data_in    (data_in),
    .ack_out    (ack_out),
    .dout_valid (dout_valid),
    .dout_data  (dout_data),
    .dout_ready (dout_ready),
    .evt_dot    (evt_dot),
    .evt_blank  (evt_blank),
    .level      (level)
  );

  twophase_sync_rx #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(3)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req3),
    .data_in    (data3),
    .ack_out    (ack3),
    .dout_valid (valid3),
    .dout_data  (dout3),
    .dout_ready (ready3),
    .evt_dot    (dot3),
    .evt_blank  (blank3),
    .level      (level3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Toggle req with new data at a negedge and wait (bounded) for the ack.
  task automatic send_evt(input logic [7:0] d, output int lat,
                          output logic dot, output logic blank);
    data_in = d;
    req_in  = ~req_in;
    lat     = 0;
    dot     = 1'b0;
    blank   = 1'b0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (ack_out == req_in) begin
        dot   = evt_dot;
        blank = evt_blank;
        break;
      end
    end
    chk("ack_seen", 32'(ack_out == req_in), 32'd1);
  endtask

  int   lat, lat_s, cnt, exp_d, cyc, max_lvl;
  logic dot, blank, dot_s, blank_s;

  initial begin
    rst = 1'b1; req_in = 1'b0; data_in = 8'h00; dout_ready = 1'b0;
    req3 = 1'b0; data3 = 8'h00; ready3 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack",   32'(ack_out),    32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_level", 32'(level),      32'd0);
    chk("rst_evt",   32'({evt_dot, evt_blank}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single rising event: accepted on the third edge after the toggle.
    data_in = 8'hA5; req_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("t1_ack_early", 32'(ack_out), 32'd0);
    @(negedge clk);
    chk("t1_ack",   32'(ack_out),    32'd1);
    chk("t1_dot",   32'(evt_dot),    32'd1);
    chk("t1_blank", 32'(evt_blank),  32'd0);
    chk("t1_valid", 32'(dout_valid), 32'd1);
    chk("t1_data",  32'(dout_data),  32'hA5);
    chk("t1_level", 32'(level),      32'd1);
    @(negedge clk);
    chk("t1_dot_once", 32'(evt_dot), 32'd0);

    // Reset the pair so the next handshake starts from phase 0.
    rst = 1'b1; req_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("t2_level0", 32'(level), 32'd0);

    for (int i = 0; i < 4; i++) begin
      send_evt(8'(i + 1), lat, dot, blank);
      chk("t2_ack",   32'(ack_out), 32'((i % 2) == 0));
      chk("t2_dot",   32'(dot),     32'((i % 2) == 0));
      chk("t2_blank", 32'(blank),   32'((i % 2) == 1));
    end
    chk("t2_level4", 32'(level),     32'd4);
    chk("t2_head",   32'(dout_data), 32'h01);

    data_in = 8'h05; req_in = ~req_in;
    repeat (6) @(negedge clk);
    chk("t2_stall_ack",   32'(ack_out), 32'd0);
    chk("t2_stall_level", 32'(level),   32'd4);
    chk("t2_stall_evt",   32'({evt_dot, evt_blank}), 32'd0);

    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    chk("t2_pp_ack",   32'(ack_out),   32'd1);
    chk("t2_pp_level", 32'(level),     32'd4);
    chk("t2_pp_dot",   32'(evt_dot),   32'd1);
    chk("t2_pp_head",  32'(dout_data), 32'h02);

    dout_ready = 1'b1;
    for (int j = 2; j <= 5; j++) begin
      chk("t2_drain_valid", 32'(dout_valid), 32'd1);
      chk("t2_drain_data",  32'(dout_data),  32'(j));
      @(negedge clk);
    end
    dout_ready = 1'b0;
    chk("t2_empty", 32'(dout_valid), 32'd0);
    chk("t2_lvl0",  32'(level),      32'd0);

    // Streaming with the consumer always ready.
    dout_ready = 1'b1;
    exp_d = 0; cyc = 0; max_lvl = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) send_evt(8'(i), lat_s, dot_s, blank_s);
      end
      begin
        while (exp_d < 20 && cyc < 500) begin
          @(negedge clk);
          cyc++;
          if (int'(level) > max_lvl) max_lvl = int'(level);
          if (dout_valid) begin
            chk("t3_data", 32'(dout_data), 32'(exp_d));
            exp_d++;
          end
        end
      end
    join
    chk("t3_count", 32'(exp_d), 32'd20);
    chk("t3_maxlvl", 32'(max_lvl <= 2), 32'd1);
    repeat (3) @(negedge clk);
    chk("t3_no_dup", 32'(dout_valid), 32'd0);

    // Reset with three buffered entries and one event in flight.
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_evt(8'(8'h40 + i), lat, dot, blank);
    chk("t4_level3", 32'(level), 32'd3);
    data_in = 8'h43; req_in = ~req_in;
    @(negedge clk);
    rst = 1'b1; req_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_ack",   32'(ack_out),    32'd0);
    chk("t4_level", 32'(level),      32'd0);
    chk("t4_valid", 32'(dout_valid), 32'd0);
    chk("t4_evt",   32'({evt_dot, evt_blank}), 32'd0);
    repeat (5) @(negedge clk);
    chk("t4_quiet", 32'({ack_out, level}), 32'd0);
    send_evt(8'h77, lat, dot, blank);
    chk("t4_new_ack",  32'(ack_out),   32'd1);
    chk("t4_new_dot",  32'(dot),       32'd1);
    chk("t4_new_data", 32'(dout_data), 32'h77);
    chk("t4_new_lvl",  32'(level),     32'd1);

    // Three-stage synchronizer with random req phase inside the clock period.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #($urandom_range(1, 9));
      data3 = 8'(8'h30 + i);
      req3  = ~req3;
      cnt   = 0;
      while (cnt < 20 && ack3 != req3) begin
        @(posedge clk);
        #1;
        cnt++;
      end
      chk("t5_ack_seen", 32'(ack3 == req3), 32'd1);
      chk("t5_latency",  32'(cnt >= 3 && cnt <= 4), 32'd1);
      chk("t5_level",    32'(level3), 32'd1);
      chk("t5_data",     32'(dout3),  32'(8'h30 + i));
      ready3 = 1'b1;
      @(posedge clk);
      #1;
      ready3 = 1'b0;
      chk("t5_popped", 32'(level3), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
